// File: rtl/shared_fpu_arbiter_pkg.sv
// Shared FPU arbiter package: op encoding, tag sizing and the sign-flip helper
// that turns a subtract into an add.
package shared_fpu_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Tag width needed to name one of n requesters (at least one bit)
  function automatic int tag_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

  // Subtraction is issued as addition with the rhs sign inverted
  function automatic logic flip_sign(input logic sign, input logic op);
    return (op == OP_ADD) ? sign : ~sign;
  endfunction

endpackage

// File: rtl/shared_fpu_arbiter_rr.sv
// Round-robin arbiter: the search begins at rr_ptr and wraps upward; the
// pointer moves one past the winner on every grant and holds otherwise.
module rr_arbiter
  import shared_fpu_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TW      = tag_width(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant,
  output logic [TW-1:0]      grant_idx
);

  logic [TW-1:0] rr_ptr_q, rr_ptr_d;
  logic          found;
  int            cand;

  // Rotating-priority search for the first valid requester at or above rr_ptr
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    cand      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(rr_ptr_q) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!found && enable && req[TW'(cand)]) begin
        found     = 1'b1;
        grant_idx = TW'(cand);
      end
    end
  end

  // One-hot view of the winner
  always_comb begin
    grant = '0;
    if (found) grant[grant_idx] = 1'b1;
  end

  // Advance the pointer past the winner; hold when nothing was granted
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (found) rr_ptr_d = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + TW'(1);
  end

  // Pointer register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rr_ptr_q <= '0;
    else      rr_ptr_q <= rr_ptr_d;
  end

endmodule

// File: rtl/shared_fpu_arbiter.sv
// Shares one pipelined add/sub core among NUM_REQ requesters. A tag pipe runs
// in lockstep with the core (both advance only on fpu_ce) so each result is
// steered back to its issuer. The core stalls whenever the head result's
// consumer is not ready; the pipe is strictly in order.
// Optional: define SHARED_FPU_OCCUPANCY_EN to add the registered occupancy port.
module shared_fpu_arbiter
  import shared_fpu_pkg::*;
#(
  parameter int DATA_TYPE = 32,
  parameter int NUM_REQ   = 4,
  parameter int LATENCY   = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_REQ-1:0][DATA_TYPE-1:0] ins_lhs,
  input  logic [NUM_REQ-1:0][DATA_TYPE-1:0] ins_rhs,
  input  logic [NUM_REQ-1:0]                ins_op,
  input  logic [NUM_REQ-1:0]                ins_valid,
  output logic [NUM_REQ-1:0]                ins_ready,
  output logic [NUM_REQ-1:0][DATA_TYPE-1:0] outs,
  output logic [NUM_REQ-1:0]                outs_valid,
  input  logic [NUM_REQ-1:0]                outs_ready,
  output logic                              fpu_ce,
  output logic [DATA_TYPE-1:0]              fpu_x,
  output logic [DATA_TYPE-1:0]              fpu_y,
  input  logic [DATA_TYPE-1:0]              fpu_r
`ifdef SHARED_FPU_OCCUPANCY_EN
  ,
  output logic [$clog2(LATENCY+1)-1:0]      occupancy
`endif
);

  localparam int TW = tag_width(NUM_REQ);

  logic [LATENCY-1:0]         vld_q, vld_d;
  logic [LATENCY-1:0][TW-1:0] tag_q, tag_d;
  logic [NUM_REQ-1:0]         grant;
  logic [TW-1:0]              g_idx;
  logic                       head_vld, head_ready, issue;

  assign head_vld   = vld_q[LATENCY-1];
  assign head_ready = outs_ready[tag_q[LATENCY-1]];
  // Core runs unless the head holds a result nobody can take; forced on in reset to flush
  assign fpu_ce     = !rst || !head_vld || head_ready;
  assign issue      = |grant;
  assign ins_ready  = grant;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .TW      (TW)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (ins_valid),
    .enable    (fpu_ce && rst),
    .grant     (grant),
    .grant_idx (g_idx)
  );

  // Every output channel sees the core result; the valid picks the owner
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_out
    assign outs[i]       = fpu_r;
    assign outs_valid[i] = rst && head_vld && (tag_q[LATENCY-1] == TW'(i));
  end

  // Winner's operands; subtract becomes add of the sign-flipped rhs
  assign fpu_x = ins_lhs[g_idx];
  assign fpu_y = {flip_sign(ins_rhs[g_idx][DATA_TYPE-1], ins_op[g_idx]),
                  ins_rhs[g_idx][DATA_TYPE-2:0]};

  // Tag pipe shifts with the core; stage 0 takes the new grant (or a bubble)
  always_comb begin
    vld_d = vld_q;
    tag_d = tag_q;
    if (fpu_ce) begin
      for (int k = LATENCY - 1; k >= 1; k--) begin
        vld_d[k] = vld_q[k-1];
        tag_d[k] = tag_q[k-1];
      end
      vld_d[0] = issue;
      tag_d[0] = g_idx;
    end
  end

  // Tag pipe registers; reset discards everything in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= '0;
      tag_q <= '0;
    end else begin
      vld_q <= vld_d;
      tag_q <= tag_d;
    end
  end

`ifdef SHARED_FPU_OCCUPANCY_EN
  localparam int OW = $clog2(LATENCY + 1);

  logic [OW-1:0] occ_q, occ_d;
  logic          xfer;

  assign xfer      = head_vld && head_ready;
  assign occupancy = occ_q;

  // In-flight count: up on grant, down on head transfer, hold when both
  always_comb begin
    occ_d = occ_q;
    case ({issue, xfer})
      2'b10:   occ_d = occ_q + OW'(1);
      2'b01:   occ_d = occ_q - OW'(1);
      default: occ_d = occ_q;
    endcase
  end

  // Occupancy register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) occ_q <= '0;
    else      occ_q <= occ_d;
  end
`endif

endmodule

// File: tb/tb_shared_fpu_arbiter.sv
// Bench for shared_fpu_arbiter: a mock core (x+y as raw integers, LATENCY
// stages gated by fpu_ce), per-requester stimulus tables, and a scoreboard
// filled at each handshake and drained by a monitor on each result transfer.
module tb_shared_fpu_arbiter;
  import shared_fpu_pkg::*;

  localparam int NR  = 4;
  localparam int DW  = 32;
  localparam int LAT = 8;
  localparam int DEP = 32;

  typedef struct {
    int            idx;
    logic [DW-1:0] val;
  } exp_t;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [NR-1:0][DW-1:0]  ins_lhs, ins_rhs, outs;
  logic [NR-1:0]          ins_op, ins_valid, ins_ready, outs_valid, outs_ready;
  logic                   fpu_ce;
  logic [DW-1:0]          fpu_x, fpu_y, fpu_r;
`ifdef SHARED_FPU_OCCUPANCY_EN
  logic [$clog2(LAT+1)-1:0] occupancy;
`endif

  int            checks = 0;
  int            errors = 0;
  exp_t          exp_q[$];
  int            gq[$];
  logic [DW-1:0] s_lhs [NR][DEP];
  logic [DW-1:0] s_rhs [NR][DEP];
  logic          s_op  [NR][DEP];
  int            s_wr  [NR];
  int            s_rd  [NR];
  logic [NR-1:0] nxt_ready;
  logic [DW-1:0] core_q [LAT];
  int            lat;

  always #5 clk = ~clk;

  shared_fpu_arbiter #(.DATA_TYPE(DW), .NUM_REQ(NR), .LATENCY(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .ins_lhs    (ins_lhs),
    .ins_rhs    (ins_rhs),
    .ins_op     (ins_op),
    .ins_valid  (ins_valid),
    .ins_ready  (ins_ready),
    .outs       (outs),
    .outs_valid (outs_valid),
    .outs_ready (outs_ready),
    .fpu_ce     (fpu_ce),
    .fpu_x      (fpu_x),
    .fpu_y      (fpu_y),
    .fpu_r      (fpu_r)
`ifdef SHARED_FPU_OCCUPANCY_EN
    ,
    .occupancy  (occupancy)
`endif
  );

  // Mock core: integer add stands in for the FP adder, gated by fpu_ce
  always @(posedge clk) begin
    if (fpu_ce) begin
      core_q[0] <= fpu_x + fpu_y;
      for (int k = 1; k < LAT; k++) core_q[k] <= core_q[k-1];
    end
  end
  assign fpu_r = core_q[LAT-1];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic push_op(input int r, input logic [DW-1:0] l, input logic [DW-1:0] h, input logic op);
    s_lhs[r][s_wr[r]] = l;
    s_rhs[r][s_wr[r]] = h;
    s_op[r][s_wr[r]]  = op;
    s_wr[r]++;
  endtask

  // Present the head of each requester's table
  task automatic drive();
    outs_ready = nxt_ready;
    for (int r = 0; r < NR; r++) begin
      if (s_rd[r] < s_wr[r]) begin
        ins_valid[r] = 1'b1;
        ins_lhs[r]   = s_lhs[r][s_rd[r]];
        ins_rhs[r]   = s_rhs[r][s_rd[r]];
        ins_op[r]    = s_op[r][s_rd[r]];
      end else begin
        ins_valid[r] = 1'b0;
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    drive();
    @(negedge clk);
  endtask

  task automatic drain();
    for (int n = 0; n < 200 && exp_q.size() > 0; n++) cyc();
    cyc();
    chk("drain_empty", exp_q.size(), 0);
  endtask

  // Monitor: check delivered results, then log new handshakes into the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      for (int r = 0; r < NR; r++) begin
        if (outs_valid[r] && outs_ready[r]) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL out_spurious req=%0d actual=%h required=none", r, outs[r]);
          end else begin
            e = exp_q.pop_front();
            chk("out_tag", r, e.idx);
            chk("out_data", outs[r], e.val);
          end
        end
      end
      for (int r = 0; r < NR; r++) begin
        if (ins_valid[r] && ins_ready[r]) begin
          e.idx = r;
          e.val = s_lhs[r][s_rd[r]] + (s_rhs[r][s_rd[r]] ^ {s_op[r][s_rd[r]], {(DW-1){1'b0}}});
          exp_q.push_back(e);
          gq.push_back(r);
          s_rd[r]++;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int r = 0; r < NR; r++) begin
      s_wr[r] = 0;
      s_rd[r] = 0;
    end
    ins_lhs = '0; ins_rhs = '0; ins_op = '0; ins_valid = '0;
    nxt_ready = '1; outs_ready = '1;

    // Reset with every requester valid, two ops each
    for (int r = 0; r < NR; r++)
      for (int k = 0; k < 2; k++)
        push_op(r, 32'h1000_0000 * (r + 1) + k, 32'h0000_0100 * (k + 1), (k == 1));
    drive();
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ins_ready", ins_ready, 0);
    chk("rst_outs_valid", outs_valid, 0);
    chk("rst_fpu_ce", fpu_ce, 1);
`ifdef SHARED_FPU_OCCUPANCY_EN
    chk("rst_occupancy", occupancy, 0);
`endif
    @(posedge clk);
    #1 rst = 1'b1;
    drive();
    @(negedge clk);
    chk("first_grant", ins_ready, 4'b0001);

    // Fairness: strict rotation while all are valid
    repeat (8) cyc();
    chk("fair_count", gq.size(), 8);
    for (int k = 0; k < 8; k++)
      if (k < gq.size()) chk("fair_order", gq[k], k % 4);
    drain();

    // Single request on req2: exactly LATENCY cycles to outs_valid
    push_op(2, 32'h3F80_0000, 32'h4000_0000, OP_ADD);
    cyc();
    chk("single_grant", ins_ready, 4'b0100);
    lat = 0;
    while (lat < 20 && !outs_valid[2]) begin
      cyc();
      lat++;
    end
    chk("single_latency", lat, 8);
    chk("single_data", outs[2], 32'h7F80_0000);
    drain();

    // Subtract: rhs sign flipped on fpu_y
    push_op(1, 32'h3F80_0000, 32'h4000_0000, OP_SUB);
    cyc();
    chk("sub_grant", ins_ready, 4'b0010);
    chk("sub_fpu_x", fpu_x, 32'h3F80_0000);
    chk("sub_fpu_y", fpu_y, 32'hC000_0000);
    drain();

    // Subtract of a negative rhs clears the sign
    push_op(3, 32'h4040_0000, 32'hC000_0000, OP_SUB);
    cyc();
    chk("subneg_grant", ins_ready, 4'b1000);
    chk("subneg_fpu_y", fpu_y, 32'h4000_0000);
    drain();

    // Backpressure: requester 1 not ready, head tagged 1 freezes the pipe
    nxt_ready = 4'b1101;
    for (int k = 0; k < 3; k++) push_op(0, 32'h0000_1000 + k, 32'h0000_0010, (k == 2));
    for (int k = 0; k < 2; k++) push_op(1, 32'h0000_2000 + k, 32'h0000_0020, 1'b0);
    push_op(2, 32'h0000_3000, 32'h8000_0030, 1'b1);
    cyc();
    lat = 0;
    while (lat < 40 && !outs_valid[1]) begin
      cyc();
      lat++;
    end
    chk("bp_head", outs_valid, 4'b0010);
    chk("bp_ce", fpu_ce, 0);
    chk("bp_ins_ready", ins_ready, 0);
    push_op(3, 32'h0000_4000, 32'h0000_0040, 1'b0);
    repeat (3) begin
      cyc();
      chk("bp_frozen", outs_valid, 4'b0010);
      chk("bp_ready_low", ins_ready, 0);
      chk("bp_ce_low", fpu_ce, 0);
    end
`ifdef SHARED_FPU_OCCUPANCY_EN
    chk("bp_occupancy", occupancy, 5);
`endif
    nxt_ready = '1;
    cyc();
    chk("bp_release_grant", ins_ready, 4'b1000);
    chk("bp_release_ce", fpu_ce, 1);
    drain();

    // Mid-flight reset with five ops in the pipe
    for (int k = 0; k < 5; k++) push_op(0, 32'h0000_5000 + k, 32'h0000_0001, 1'b0);
    repeat (5) cyc();
    @(posedge clk);
    #1;
`ifdef SHARED_FPU_OCCUPANCY_EN
    chk("mid_occupancy", occupancy, 5);
`endif
    rst = 1'b0;
    s_wr[0] = s_rd[0];
    exp_q.delete();
    drive();
    @(negedge clk);
    chk("mid_rst_ins_ready", ins_ready, 0);
    chk("mid_rst_outs_valid", outs_valid, 0);
    chk("mid_rst_fpu_ce", fpu_ce, 1);
    @(posedge clk);
    #1 rst = 1'b1;
    drive();
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      chk("post_rst_quiet", outs_valid, 0);
      cyc();
    end
`ifdef SHARED_FPU_OCCUPANCY_EN
    chk("post_rst_occupancy", occupancy, 0);
`endif
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
